// File: rtl/fnn_ctrl_pkg.sv
// ============================================================================
// Module  : fnn_ctrl_pkg
// Brief   : Shared phase codes and helpers for the FNN controller slice
//           (master_controller -> layer_step_controller).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fnn_ctrl_pkg;

  typedef logic [2:0] ctrl_t;

  localparam ctrl_t CTRL_IDLE = 3'd0;
  localparam ctrl_t CTRL_LOAD = 3'd1;
  localparam ctrl_t CTRL_MAC  = 3'd2;
  localparam ctrl_t CTRL_ACT  = 3'd3;
  localparam ctrl_t CTRL_NEXT = 3'd5;

  // Codes 4, 6 and 7 carry no meaning; the consumer treats them as IDLE.
  function automatic logic is_reserved(input ctrl_t code);
    return (code == 3'd4) || (code == 3'd6) || (code == 3'd7);
  endfunction

endpackage

`default_nettype wire

// File: rtl/layer_step_controller_wrap_counter.sv
// ============================================================================
// Module  : wrap_counter
// Brief   : Modulo-MOD up-counter with synchronous clear and a combinational
//           wrap flag that is high on the enabled terminal count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wrap_counter #(
  parameter int MOD = 5,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         wrap
);

  logic [W-1:0] r_q;

  assign q    = r_q;
  assign wrap = en && (r_q == W'(MOD - 1));

  // Count on enable, fold back to zero at MOD-1; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= wrap ? '0 : r_q + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/layer_step_controller.sv
// ============================================================================
// Module  : layer_step_controller
// Brief   : Turns the master_controller phase code into registered per-cycle
//           strobes and addresses for the neuron array, and tracks the
//           current layer plus layer/network completion.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_step_controller
  import fnn_ctrl_pkg::*;
#(
  parameter  int max      = 5,
  parameter  int layer_no = 4,
  localparam int CNT_W    = $clog2(max),
  localparam int LAY_W    = $clog2(layer_no),
  localparam int WA_W     = $clog2(layer_no * max * max)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       control,
  output logic [WA_W-1:0]  w_addr,
  output logic [CNT_W-1:0] in_sel,
  output logic [CNT_W-1:0] neu_sel,
  output logic [LAY_W-1:0] layer_idx,
  output logic             ld_en,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             wr_en,
  output logic [CNT_W-1:0] wr_neu,
  output logic             act_en,
  output logic             layer_done,
  output logic             net_done,
  output logic             ctrl_err
);

  // Phase decode
  logic w_load;
  logic w_mac;
  logic w_act;
  logic w_next;
  logic w_rsv;
  logic w_mac_go;
  logic w_cnt_clr;

  assign w_load    = (control == CTRL_LOAD);
  assign w_mac     = (control == CTRL_MAC);
  assign w_act     = (control == CTRL_ACT);
  assign w_next    = (control == CTRL_NEXT);
  assign w_rsv     = is_reserved(control);
  // Once a layer is fully accumulated further MAC phases are dropped silently.
  assign w_mac_go  = w_mac && !layer_done;
  assign w_cnt_clr = w_load || w_next;

  // Counter state
  logic [CNT_W-1:0] w_i_q;
  logic [CNT_W-1:0] w_j_q;
  logic [LAY_W-1:0] w_lay_q;
  logic             w_i_wrap;
  logic             w_j_wrap;
  logic             w_lay_wrap;

  wrap_counter #(.MOD(max), .W(CNT_W)) u_i_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_cnt_clr),
    .en    (w_mac_go),
    .q     (w_i_q),
    .wrap  (w_i_wrap)
  );

  wrap_counter #(.MOD(max), .W(CNT_W)) u_j_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_cnt_clr),
    .en    (w_i_wrap),
    .q     (w_j_q),
    .wrap  (w_j_wrap)
  );

  // Layer index survives LOAD/NEXT clears; only reset or the NEXT wrap zero it.
  wrap_counter #(.MOD(layer_no), .W(LAY_W)) u_lay_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (w_next),
    .q     (w_lay_q),
    .wrap  (w_lay_wrap)
  );

  assign layer_idx = w_lay_q;

  // Weight address = layer*max*max + j*max + i, built at full address width.
  logic [WA_W-1:0] w_addr_nxt;

  assign w_addr_nxt = (WA_W'(w_lay_q) * WA_W'(max * max))
                    + (WA_W'(w_j_q) * WA_W'(max))
                    + WA_W'(w_i_q);

  // Write-back is deferred one cycle behind the last product of a neuron.
  logic             r_wr_pend;
  logic [CNT_W-1:0] r_wr_j;

  // Registered strobes, addresses and sticky status, one cycle after control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_addr     <= '0;
      in_sel     <= '0;
      neu_sel    <= '0;
      ld_en      <= 1'b0;
      mac_en     <= 1'b0;
      mac_clr    <= 1'b0;
      wr_en      <= 1'b0;
      wr_neu     <= '0;
      act_en     <= 1'b0;
      layer_done <= 1'b0;
      net_done   <= 1'b0;
      ctrl_err   <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_wr_j     <= '0;
    end else begin
      ld_en     <= 1'b0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      act_en    <= 1'b0;
      r_wr_pend <= 1'b0;

      // A pending write-back fires regardless of the current phase and
      // carries the neuron index captured before any LOAD/NEXT clear.
      wr_en <= r_wr_pend;
      if (r_wr_pend) begin
        wr_neu <= r_wr_j;
      end

      if (w_rsv) begin
        ctrl_err <= 1'b1;
      end

      if (w_load) begin
        ld_en      <= 1'b1;
        layer_done <= 1'b0;
        if (w_lay_q == '0) begin
          net_done <= 1'b0;
        end
      end

      if (w_mac_go) begin
        mac_en    <= 1'b1;
        mac_clr   <= (w_i_q == '0);
        in_sel    <= w_i_q;
        neu_sel   <= w_j_q;
        w_addr    <= w_addr_nxt;
        r_wr_pend <= w_i_wrap;
        r_wr_j    <= w_j_q;
        if (w_j_wrap) begin
          layer_done <= 1'b1;
        end
      end

      if (w_act) begin
        act_en <= 1'b1;
      end

      if (w_next) begin
        layer_done <= 1'b0;
        if (w_lay_wrap) begin
          net_done <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_layer_step_controller.sv
// ============================================================================
// Module  : tb_layer_step_controller
// Brief   : Self-checking bench: directed phase sequences followed by random
//           phase codes and occasional asynchronous resets, compared against
//           a flat-index behavioural model of the layer controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_layer_step_controller;

  localparam int MAXN  = 5;
  localparam int LAYN  = 4;
  localparam int CNT_W = $clog2(MAXN);
  localparam int LAY_W = $clog2(LAYN);
  localparam int WA_W  = $clog2(LAYN * MAXN * MAXN);

  logic             clk;
  logic             rst_n;
  logic [2:0]       control;
  logic [WA_W-1:0]  w_addr;
  logic [CNT_W-1:0] in_sel;
  logic [CNT_W-1:0] neu_sel;
  logic [LAY_W-1:0] layer_idx;
  logic             ld_en;
  logic             mac_en;
  logic             mac_clr;
  logic             wr_en;
  logic [CNT_W-1:0] wr_neu;
  logic             act_en;
  logic             layer_done;
  logic             net_done;
  logic             ctrl_err;

  layer_step_controller #(.max(MAXN), .layer_no(LAYN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .control    (control),
    .w_addr     (w_addr),
    .in_sel     (in_sel),
    .neu_sel    (neu_sel),
    .layer_idx  (layer_idx),
    .ld_en      (ld_en),
    .mac_en     (mac_en),
    .mac_clr    (mac_clr),
    .wr_en      (wr_en),
    .wr_neu     (wr_neu),
    .act_en     (act_en),
    .layer_done (layer_done),
    .net_done   (net_done),
    .ctrl_err   (ctrl_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: progress through a layer is a single flat index
  // k = neuron*MAXN + input, so the weight address is simply lay*MAXN^2 + k.
  int m_k, m_lay, m_ldone, m_ndone, m_err, m_pend, m_pend_neu;
  int e_addr, e_in, e_neu, e_ld, e_mac, e_clr, e_wr, e_wrneu, e_act;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_lay = 0; m_ldone = 0; m_ndone = 0; m_err = 0;
    m_pend = 0; m_pend_neu = 0;
    e_addr = 0; e_in = 0; e_neu = 0; e_ld = 0; e_mac = 0; e_clr = 0;
    e_wr = 0; e_wrneu = 0; e_act = 0;
  endtask

  task automatic model_step(input int c);
    e_ld = 0; e_mac = 0; e_clr = 0; e_act = 0;
    e_wr = m_pend;
    if (m_pend != 0) e_wrneu = m_pend_neu;
    m_pend = 0;
    case (c)
      1: begin
        e_ld = 1; m_k = 0; m_ldone = 0;
        if (m_lay == 0) m_ndone = 0;
      end
      2: begin
        if (m_ldone == 0) begin
          e_mac  = 1;
          e_in   = m_k % MAXN;
          e_neu  = m_k / MAXN;
          e_clr  = (e_in == 0) ? 1 : 0;
          e_addr = m_lay * MAXN * MAXN + m_k;
          if (e_in == MAXN - 1) begin
            m_pend = 1; m_pend_neu = e_neu;
          end
          m_k++;
          if (m_k == MAXN * MAXN) begin
            m_k = 0; m_ldone = 1;
          end
        end
      end
      3: e_act = 1;
      5: begin
        m_k = 0; m_ldone = 0;
        if (m_lay == LAYN - 1) begin
          m_lay = 0; m_ndone = 1;
        end else begin
          m_lay++;
        end
      end
      4, 6, 7: m_err = 1;
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("w_addr",     32'(w_addr),     32'(e_addr));
    check("in_sel",     32'(in_sel),     32'(e_in));
    check("neu_sel",    32'(neu_sel),    32'(e_neu));
    check("layer_idx",  32'(layer_idx),  32'(m_lay));
    check("ld_en",      32'(ld_en),      32'(e_ld));
    check("mac_en",     32'(mac_en),     32'(e_mac));
    check("mac_clr",    32'(mac_clr),    32'(e_clr));
    check("wr_en",      32'(wr_en),      32'(e_wr));
    check("wr_neu",     32'(wr_neu),     32'(e_wrneu));
    check("act_en",     32'(act_en),     32'(e_act));
    check("layer_done", 32'(layer_done), 32'(m_ldone));
    check("net_done",   32'(net_done),   32'(m_ndone));
    check("ctrl_err",   32'(ctrl_err),   32'(m_err));
  endtask

  // Drive one phase code, let the DUT take it, compare on the falling edge.
  task automatic step(input int c);
    control = 3'(c);
    @(posedge clk);
    model_step(c);
    @(negedge clk);
    compare_all();
  endtask

  // Short asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #1;
    rst_n = 1'b0;
    #0.5;
    model_reset();
    compare_all();
    #0.5;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    control = 3'd0;
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;

    // Full layer 0, then MACs past completion, ACT, and into layer 1.
    step(1);
    for (int n = 0; n < 25; n++) step(2);
    for (int n = 0; n < 3; n++) step(2);
    step(3); step(3);
    step(5);
    step(1);
    step(2);

    // Walk the remaining layers to the network wrap, then clear net_done.
    step(5); step(5); step(5);
    step(0);
    step(1);

    // Reset in the middle of a layer, then restart.
    for (int n = 0; n < 11; n++) step(2);
    pulse_reset();
    step(1);
    for (int n = 0; n < 3; n++) step(2);

    // Reserved code mid-MAC.
    step(7);
    for (int n = 0; n < 4; n++) step(2);

    // Random phase codes, weighted toward MAC so layers actually complete.
    for (int n = 0; n < 800; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60)      step(2);
      else if (r < 67) step(1);
      else if (r < 75) step(3);
      else if (r < 83) step(5);
      else if (r < 92) step(0);
      else if (r < 94) step(4);
      else if (r < 96) step(6);
      else if (r < 98) step(7);
      else             pulse_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
